sis_crdata_fetch: RTL and testbench

- Upstream feeder for the generic CR-data converter.
- Given a CRT1 timing-table base pointer and a mode index, fetches one REC_BYTES-byte CR record from memory over a 64-bit Avalon-MM read master.
- Unpacks the record from arbitrary byte alignment and presents it as a flat byte vector with an HLS-style call/return handshake.
- The converter consumes the record without issuing its own byte reads.

---
 rtl/sis_crfetch_pkg.sv | 28 ++
 rtl/sis_crdata_align.sv | 27 ++
 rtl/sis_crdata_fetch.sv | 164 ++++++++++++++++
 tb/tb_sis_crdata_fetch.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sis_crfetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sis_crfetch_pkg
// Description : Shared types and constants for the CR-data record fetcher:
//               FSM state encoding, default record size, bus width and the
//               helper that sizes a fetch in bus words.
// Revision    : 1.0 - initial release
// ============================================================================
package sis_crfetch_pkg;

   localparam int c_REC_BYTES_DEF = 17;
   localparam int c_BUS_W         = 64;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_REQ  = 3'd1,
      ST_WAIT = 3'd2,
      ST_PACK = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   // Number of 8-byte bus words touched by a record starting at byte offset off.
   function automatic int calc_nwords(input int off, input int rec_bytes);
      return (off + rec_bytes + 7) >> 3;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sis_crdata_align.sv
`default_nettype none
// ============================================================================
// Module      : sis_crdata_align
// Description : Combinational byte shifter. Extracts REC_BYTES consecutive
//               bytes starting at byte offset off from the little-endian
//               concatenation of the fetched bus words.
// Revision    : 1.0 - initial release
// ============================================================================
module sis_crdata_align
   import sis_crfetch_pkg::*;
#(
   parameter int REC_BYTES = c_REC_BYTES_DEF,
   parameter int MAX_WORDS = 8
) (
   input  logic [MAX_WORDS*c_BUS_W-1:0] buf_flat,
   input  logic [2:0]                   off,
   output logic [8*REC_BYTES-1:0]       rec
);

   localparam int c_RW = 8 * REC_BYTES;

   // Word 0 holds the lowest addresses, so a right shift by off bytes
   // brings the first record byte down to bit 0.
   assign rec = c_RW'(buf_flat >> {off, 3'b000});

endmodule
`default_nettype wire

// File: rtl/sis_crdata_fetch.sv
`default_nettype none
// ============================================================================
// Module      : sis_crdata_fetch
// Description : Fetches one REC_BYTES-byte CR record at
//               table_base + mode_index*REC_BYTES over a 64-bit Avalon-MM
//               read master (one outstanding read), realigns it and returns
//               it as a flat byte vector through a call/return handshake.
//               Optional build macro SIS_CRFETCH_CACHE_EN adds a one-entry
//               record-address tag so a repeated call returns immediately.
// Revision    : 1.0 - initial release
// ============================================================================
module sis_crdata_fetch
   import sis_crfetch_pkg::*;
#(
   parameter int REC_BYTES = c_REC_BYTES_DEF,
   parameter int MAX_WORDS = 8
) (
   input  logic                   clock,
   input  logic                   resetn,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   input  logic                   stall,
   input  logic [63:0]            table_base,
   input  logic [15:0]            mode_index,
   output logic [8*REC_BYTES-1:0] crdata_out,
   output logic [63:0]            avmm_0_rw_address,
   output logic [7:0]             avmm_0_rw_byteenable,
   output logic                   avmm_0_rw_read,
   input  logic                   avmm_0_rw_waitrequest,
   input  logic                   avmm_0_rw_readdatavalid,
   input  logic [63:0]            avmm_0_rw_readdata,
   output logic                   avmm_0_rw_write,
   output logic [63:0]            avmm_0_rw_writedata
);

   localparam int c_RW = 8 * REC_BYTES;
   localparam int c_KW = $clog2(MAX_WORDS + 1);
   localparam int c_IW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

   state_t                       r_state;
   state_t                       w_state_next;
   logic [c_BUS_W-1:0]           r_buf [MAX_WORDS];
   logic [MAX_WORDS*c_BUS_W-1:0] w_buf_flat;
   logic [c_BUS_W-1:0]           r_word_ptr;
   logic [2:0]                   r_off;
   logic [c_KW-1:0]              r_nwords;
   logic [c_KW-1:0]              r_k;
   logic [c_KW-1:0]              w_k_inc;
   logic [c_KW-1:0]              w_nwords;
   logic [c_RW-1:0]              r_crdata;
   logic [c_RW-1:0]              w_rec;
   logic [c_BUS_W-1:0]           w_rec_addr;
   logic                         w_accept;
   logic                         w_last_word;
   logic                         w_hit;

   // Record address with 64-bit wrap; the index product is zero-extended.
   assign w_rec_addr  = table_base + (c_BUS_W'(mode_index) * c_BUS_W'(REC_BYTES));
   assign w_nwords    = c_KW'(calc_nwords(int'(w_rec_addr[2:0]), REC_BYTES));
   assign w_accept    = start && (r_state == ST_IDLE);
   assign w_k_inc     = r_k + c_KW'(1);
   assign w_last_word = (w_k_inc == r_nwords);

`ifdef SIS_CRFETCH_CACHE_EN
   logic [c_BUS_W-1:0] r_tag_addr;
   logic [c_BUS_W-1:0] r_rec_addr;
   logic               r_tag_valid;

   assign w_hit = r_tag_valid && (r_tag_addr == w_rec_addr);

   // Remember the address of the last fully fetched record.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_tag_addr  <= '0;
         r_rec_addr  <= '0;
         r_tag_valid <= 1'b0;
      end else begin
         if (w_accept)
            r_rec_addr <= w_rec_addr;
         if (r_state == ST_PACK) begin
            r_tag_addr  <= r_rec_addr;
            r_tag_valid <= 1'b1;
         end
      end
   end
`else
   assign w_hit = 1'b0;
`endif

   // State register.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_next;
   end

   // Next-state decode; readdatavalid only matters while waiting for a word.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (start) w_state_next = w_hit ? ST_DONE : ST_REQ;
         ST_REQ:  if (!avmm_0_rw_waitrequest) w_state_next = ST_WAIT;
         ST_WAIT: if (avmm_0_rw_readdatavalid)
                     w_state_next = w_last_word ? ST_PACK : ST_REQ;
         ST_PACK: w_state_next = ST_DONE;
         ST_DONE: if (!stall) w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Call parameters, word buffer and the registered record.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_word_ptr <= '0;
         r_off      <= '0;
         r_nwords   <= '0;
         r_k        <= '0;
         r_crdata   <= '0;
         for (int i = 0; i < MAX_WORDS; i++)
            r_buf[i] <= '0;
      end else begin
         if (w_accept) begin
            r_word_ptr <= {w_rec_addr[63:3], 3'b000};
            r_off      <= w_rec_addr[2:0];
            r_nwords   <= w_nwords;
            r_k        <= '0;
         end
         if ((r_state == ST_WAIT) && avmm_0_rw_readdatavalid) begin
            r_buf[r_k[c_IW-1:0]] <= avmm_0_rw_readdata;
            r_k                  <= w_k_inc;
            if (!w_last_word)
               r_word_ptr <= r_word_ptr + c_BUS_W'(8);
         end
         if (r_state == ST_PACK)
            r_crdata <= w_rec;
      end
   end

   for (genvar g = 0; g < MAX_WORDS; g++) begin : g_pack
      assign w_buf_flat[g*c_BUS_W +: c_BUS_W] = r_buf[g];
   end

   sis_crdata_align #(
      .REC_BYTES (REC_BYTES),
      .MAX_WORDS (MAX_WORDS)
   ) u_align (
      .buf_flat (w_buf_flat),
      .off      (r_off),
      .rec      (w_rec)
   );

   assign busy                 = (r_state != ST_IDLE);
   assign done                 = (r_state == ST_DONE);
   assign crdata_out           = r_crdata;
   assign avmm_0_rw_address    = r_word_ptr;
   assign avmm_0_rw_read       = (r_state == ST_REQ);
   assign avmm_0_rw_byteenable = 8'hFF;
   assign avmm_0_rw_write      = 1'b0;
   assign avmm_0_rw_writedata  = '0;

endmodule
`default_nettype wire

// File: tb/tb_sis_crdata_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_sis_crdata_fetch
// Description : Self-checking bench for sis_crdata_fetch. A memory slave
//               returns byte value = address LSBs with read latency 1;
//               expected read addresses and records are queued per call.
//               Honours SIS_CRFETCH_CACHE_EN for the repeated-call case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sis_crdata_fetch;
   import sis_crfetch_pkg::*;

   localparam int REC_BYTES = 17;
   localparam int MAX_WORDS = 8;
   localparam int c_RW      = 8 * REC_BYTES;
`ifdef SIS_CRFETCH_CACHE_EN
   localparam bit c_CACHE = 1'b1;
`else
   localparam bit c_CACHE = 1'b0;
`endif

   logic             clock;
   logic             resetn;
   logic             start;
   logic             busy;
   logic             done;
   logic             stall;
   logic [63:0]      table_base;
   logic [15:0]      mode_index;
   logic [c_RW-1:0]  crdata_out;
   logic [63:0]      avmm_0_rw_address;
   logic [7:0]       avmm_0_rw_byteenable;
   logic             avmm_0_rw_read;
   logic             avmm_0_rw_waitrequest;
   logic             avmm_0_rw_readdatavalid;
   logic [63:0]      avmm_0_rw_readdata;
   logic             avmm_0_rw_write;
   logic [63:0]      avmm_0_rw_writedata;

   sis_crdata_fetch #(
      .REC_BYTES (REC_BYTES),
      .MAX_WORDS (MAX_WORDS)
   ) dut (
      .clock                   (clock),
      .resetn                  (resetn),
      .start                   (start),
      .busy                    (busy),
      .done                    (done),
      .stall                   (stall),
      .table_base              (table_base),
      .mode_index              (mode_index),
      .crdata_out              (crdata_out),
      .avmm_0_rw_address       (avmm_0_rw_address),
      .avmm_0_rw_byteenable    (avmm_0_rw_byteenable),
      .avmm_0_rw_read          (avmm_0_rw_read),
      .avmm_0_rw_waitrequest   (avmm_0_rw_waitrequest),
      .avmm_0_rw_readdatavalid (avmm_0_rw_readdatavalid),
      .avmm_0_rw_readdata      (avmm_0_rw_readdata),
      .avmm_0_rw_write         (avmm_0_rw_write),
      .avmm_0_rw_writedata     (avmm_0_rw_writedata)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   logic [63:0]     exp_addr_q [$];
   logic [c_RW-1:0] exp_rec_q  [$];

   task automatic chk(input string tag, input logic [c_RW-1:0] got, input logic [c_RW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Memory content: every byte holds the low 8 bits of its own address.
   function automatic logic [63:0] mem_word(input logic [63:0] a);
      logic [63:0] w;
      for (int b = 0; b < 8; b++)
         w[8*b +: 8] = 8'(a + 64'(b));
      return w;
   endfunction

   function automatic logic [c_RW-1:0] model_rec(input logic [63:0] ra);
      logic [c_RW-1:0] r;
      for (int i = 0; i < REC_BYTES; i++)
         r[8*i +: 8] = 8'(ra + 64'(i));
      return r;
   endfunction

   // Avalon slave: waitrequest injection, latency-1 responses, address checks.
   bit          pend         = 1'b0;
   bit          stale_inject = 1'b0;
   bit          in_hold      = 1'b0;
   logic [63:0] pend_addr    = '0;
   logic [63:0] hold_addr    = '0;
   int          rd_cnt       = 0;
   int          stall_idx    = -1;
   int          stall_left   = 0;

   always @(negedge clock) begin
      avmm_0_rw_readdatavalid = 1'b0;
      avmm_0_rw_waitrequest   = 1'b0;
      if (pend) begin
         avmm_0_rw_readdatavalid = 1'b1;
         avmm_0_rw_readdata      = mem_word(pend_addr);
         pend                    = 1'b0;
      end
      if (stale_inject) begin
         avmm_0_rw_readdatavalid = 1'b1;
         avmm_0_rw_readdata      = 64'hDEAD_BEEF_CAFE_F00D;
         stale_inject            = 1'b0;
      end
      if (resetn && avmm_0_rw_read) begin
         if (rd_cnt == stall_idx && stall_left > 0) begin
            if (in_hold)
               chk("addr_hold", c_RW'(avmm_0_rw_address), c_RW'(hold_addr));
            else
               hold_addr = avmm_0_rw_address;
            in_hold               = 1'b1;
            avmm_0_rw_waitrequest = 1'b1;
            stall_left--;
         end else begin
            if (in_hold)
               chk("addr_hold_end", c_RW'(avmm_0_rw_address), c_RW'(hold_addr));
            in_hold   = 1'b0;
            pend      = 1'b1;
            pend_addr = avmm_0_rw_address;
            rd_cnt++;
            if (exp_addr_q.size() == 0)
               chk("spurious_read", c_RW'(1), c_RW'(0));
            else
               chk("rd_addr", c_RW'(avmm_0_rw_address), c_RW'(exp_addr_q.pop_front()));
         end
      end
   end

   // One call: queue expectations, drive it, then check latency/data/return.
   task automatic do_call(input logic [63:0] base, input logic [15:0] idx, input bit hit,
                          input int exp_lat, input int stall_cyc, input string tag);
      logic [63:0]     ra;
      logic [63:0]     wp;
      logic [c_RW-1:0] held;
      int              nw;
      int              n;
      ra = base + 64'(idx) * 64'(REC_BYTES);
      nw = (int'(ra[2:0]) + REC_BYTES + 7) >> 3;
      wp = {ra[63:3], 3'b000};
      if (!hit)
         for (int w = 0; w < nw; w++)
            exp_addr_q.push_back(wp + 64'(8*w));
      exp_rec_q.push_back(model_rec(ra));
      table_base = base;
      mode_index = idx;
      stall      = (stall_cyc > 0);
      start      = 1'b1;
      @(posedge clock);
      #1;
      start      = 1'b0;
      table_base = 64'h0000_BAD0_0000_BAD0;
      mode_index = 16'hFFFF;
      n = 0;
      while (!done && n < 200) begin
         @(negedge clock);
         n++;
      end
      if (!done) begin
         chk({tag, "_timeout"}, c_RW'(0), c_RW'(1));
         exp_rec_q.delete();
         exp_addr_q.delete();
         stall = 1'b0;
         return;
      end
      chk({tag, "_latency"}, c_RW'(n), c_RW'(exp_lat));
      chk({tag, "_rec"}, crdata_out, exp_rec_q.pop_front());
      chk({tag, "_reads_left"}, c_RW'(exp_addr_q.size()), c_RW'(0));
      held = crdata_out;
      for (int i = 0; i < stall_cyc; i++) begin
         start      = (i % 2 == 0);
         table_base = 64'h9000;
         mode_index = 16'd1;
         @(negedge clock);
         chk({tag, "_hold_done"}, c_RW'(done), c_RW'(1));
         chk({tag, "_hold_rec"}, crdata_out, held);
      end
      start = 1'b0;
      stall = 1'b0;
      @(negedge clock);
      chk({tag, "_done_clr"}, c_RW'(done), c_RW'(0));
      chk({tag, "_busy_clr"}, c_RW'(busy), c_RW'(0));
   endtask

   initial begin
      resetn     = 1'b0;
      start      = 1'b0;
      stall      = 1'b0;
      table_base = '0;
      mode_index = '0;
      avmm_0_rw_readdata = '0;
      repeat (3) @(negedge clock);
      chk("rst_busy", c_RW'(busy), c_RW'(0));
      chk("rst_done", c_RW'(done), c_RW'(0));
      chk("rst_read", c_RW'(avmm_0_rw_read), c_RW'(0));
      chk("rst_addr", c_RW'(avmm_0_rw_address), c_RW'(0));
      chk("rst_rec", crdata_out, c_RW'(0));
      chk("byteenable", c_RW'(avmm_0_rw_byteenable), c_RW'(8'hFF));
      chk("write_tie", c_RW'({avmm_0_rw_write, avmm_0_rw_writedata}), c_RW'(0));
      resetn = 1'b1;
      @(negedge clock);

      do_call(64'h1000, 16'd2, 1'b0, 8, 0, "aligned");
      do_call(64'h1005, 16'd0, 1'b0, 8, 0, "unaligned");
      stall_idx  = rd_cnt + 1;
      stall_left = 3;
      do_call(64'h2000, 16'd3, 1'b0, 11, 0, "backpressure");
      do_call(64'h3001, 16'd7, 1'b0, 8, 5, "ret_stall");
      do_call(64'hFFFF_FFFF_FFFF_FFF8, 16'd1, 1'b0, 8, 0, "wrap");

      // Abort a call while the first word is in flight.
      exp_addr_q.push_back(64'h4000);
      table_base = 64'h4000;
      mode_index = 16'd0;
      start      = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      @(negedge clock);
      @(posedge clock);
      #1;
      resetn = 1'b0;
      @(negedge clock);
      @(negedge clock);
      chk("midrst_busy", c_RW'(busy), c_RW'(0));
      chk("midrst_read", c_RW'(avmm_0_rw_read), c_RW'(0));
      chk("midrst_addr", c_RW'(avmm_0_rw_address), c_RW'(0));
      chk("midrst_rec", crdata_out, c_RW'(0));
      chk("midrst_reads_left", c_RW'(exp_addr_q.size()), c_RW'(0));
      exp_addr_q.delete();
      resetn = 1'b1;
      @(negedge clock);
      stale_inject = 1'b1;
      repeat (3) @(negedge clock);
      chk("stale_busy", c_RW'(busy), c_RW'(0));
      chk("stale_done", c_RW'(done), c_RW'(0));
      chk("stale_rec", crdata_out, c_RW'(0));

      do_call(64'h1000, 16'd2, 1'b0, 8, 0, "post_reset");
      do_call(64'h1000, 16'd2, c_CACHE, c_CACHE ? 1 : 8, 0, "repeat");
      do_call(64'h1000, 16'd4, 1'b0, 8, 0, "new_index");

      repeat (3) @(negedge clock);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
